prod_accum: RTL and testbench

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_accum.sv | 96 +++++++++
 tb/tb_prod_accum.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prod_accum.sv
// prod_accum: sums COUNT consecutive accepted products from an upstream
// multiplier and presents the total with a valid/ready handshake.
// ACC collects products; HOLD keeps the finished sum until it is consumed.
module prod_accum #(
  parameter int N     = 8,
  parameter int COUNT = 4,
  localparam int AW   = 2*N + $clog2(COUNT),
  localparam int CW   = $clog2(COUNT+1)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic [2*N-1:0] P_in,
  input  logic          P_valid,
  output logic          P_ready,
  input  logic          Clear,
  output logic [AW-1:0] Sum_out,
  output logic          Sum_valid,
  input  logic          Sum_ready,
  output logic [CW-1:0] Cnt
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [CW-1:0] LAST_IDX = CW'(COUNT - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State, accumulator, count and result registers; reset discards everything.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ACC;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath: Clear wins over any product or downstream handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    if (Clear) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACC: begin
          if (P_valid) begin
            if (cnt_q == LAST_IDX) begin
              // Final product: publish the total and restart the running sum.
              sum_d   = acc_q + AW'(P_in);
              acc_d   = '0;
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              acc_d = acc_q + AW'(P_in);
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          // Products are refused here, so P_valid is irrelevant.
          if (Sum_ready) begin
            state_d = ACC;
          end
        end
        default: begin
          state_d = ACC;
        end
      endcase
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    P_ready   = (state_q == ACC);
    Sum_valid = (state_q == HOLD);
    Sum_out   = sum_q;
    Cnt       = cnt_q;
  end

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based behavioural model of the accumulator.
module tb_prod_accum;

  localparam int N     = 8;
  localparam int COUNT = 4;
  localparam int AW    = 2*N + $clog2(COUNT);
  localparam int CW    = $clog2(COUNT+1);

  logic           clk = 1'b0;
  logic           Reset = 1'b0;
  logic [2*N-1:0] P_in = '0;
  logic           P_valid = 1'b0;
  logic           P_ready;
  logic           Clear = 1'b0;
  logic [AW-1:0]  Sum_out;
  logic           Sum_valid;
  logic           Sum_ready = 1'b0;
  logic [CW-1:0]  Cnt;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: products accepted into the current sum, whether a
  // result is pending, and the last published result.
  longint m_list[$];
  bit     m_pending = 1'b0;
  longint m_out = 0;

  prod_accum #(.N(N), .COUNT(COUNT)) dut (
    .clk(clk), .Reset(Reset), .P_in(P_in), .P_valid(P_valid), .P_ready(P_ready),
    .Clear(Clear), .Sum_out(Sum_out), .Sum_valid(Sum_valid),
    .Sum_ready(Sum_ready), .Cnt(Cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_list.delete();
    m_pending = 1'b0;
    m_out = 0;
  endtask

  // Apply the rules for one rising edge using the inputs present at that edge.
  task automatic model_step();
    longint s;
    if (!Reset) begin
      model_reset();
    end else if (Clear) begin
      m_list.delete();
      m_pending = 1'b0;
    end else if (m_pending) begin
      if (Sum_ready) m_pending = 1'b0;
    end else if (P_valid) begin
      m_list.push_back(longint'(P_in));
      if (m_list.size() == COUNT) begin
        s = 0;
        foreach (m_list[i]) s += m_list[i];
        m_out = s;
        m_list.delete();
        m_pending = 1'b1;
      end
    end
  endtask

  // One clock cycle of stimulus; the model advances at the same edge.
  task automatic drive(input bit v, input longint p, input bit clr, input bit rdy);
    P_valid   = v;
    P_in      = (2*N)'(p);
    Clear     = clr;
    Sum_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic feed4(input longint a, input longint b, input longint c, input longint d);
    drive(1, a, 0, 0);
    drive(1, b, 0, 0);
    drive(1, c, 0, 0);
    drive(1, d, 0, 0);
  endtask

  task automatic pin_result(input string name, input longint exp);
    chk({name, "_model"}, m_out, exp);
    chk({name, "_sum"}, longint'(Sum_out), exp);
    chk({name, "_valid"}, longint'(Sum_valid), 1);
    chk({name, "_cnt"}, longint'(Cnt), 0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("p_ready", longint'(P_ready), longint'(!m_pending));
      chk("sum_valid", longint'(Sum_valid), longint'(m_pending));
      chk("sum_out", longint'(Sum_out), m_out);
      chk("cnt", longint'(Cnt), longint'(m_list.size()));
    end
  end

  initial begin
    // Reset held: products presented are ignored, P_ready reads 1.
    model_reset();
    P_valid = 1'b1;
    P_in = 16'd99;
    #2;
    chk("rst_p_ready", longint'(P_ready), 1);
    chk("rst_sum_valid", longint'(Sum_valid), 0);
    chk("rst_sum_out", longint'(Sum_out), 0);
    chk("rst_cnt", longint'(Cnt), 0);
    cmp_en = 1'b1;
    drive(1, 99, 0, 0);
    drive(1, 99, 0, 0);
    Reset = 1'b1;
    drive(0, 0, 0, 0);
    chk("post_rst_cnt", longint'(Cnt), 0);

    // 3+5+7+9 on consecutive cycles.
    drive(1, 3, 0, 0);
    drive(1, 5, 0, 0);
    drive(1, 7, 0, 0);
    chk("r031_not_yet", longint'(Sum_valid), 0);
    drive(1, 9, 0, 0);
    pin_result("r031", 24);
    drive(0, 0, 0, 1);

    // Maximum products: no overflow in AW bits.
    feed4(65025, 65025, 65025, 65025);
    pin_result("r032", 260100);
    drive(0, 0, 0, 1);

    // Back-pressure: result held, products refused.
    feed4(1, 2, 3, 4);
    pin_result("r033a", 10);
    for (int i = 0; i < 5; i++) begin
      drive(1, 77, 0, 0);
      chk("r033_p_ready", longint'(P_ready), 0);
      chk("r033_stable", longint'(Sum_out), 10);
    end
    drive(1, 77, 0, 1);
    chk("r033_back_acc", longint'(P_ready), 1);
    chk("r033_no_accept", longint'(Cnt), 0);
    feed4(10, 10, 10, 10);
    pin_result("r033b", 40);
    drive(0, 0, 0, 1);

    // Clear beats a simultaneous product; Sum_out keeps last value.
    drive(1, 6, 0, 0);
    drive(1, 6, 0, 0);
    chk("r034_cnt2", longint'(Cnt), 2);
    drive(1, 6, 1, 0);
    chk("r034_cnt0", longint'(Cnt), 0);
    chk("r034_retain", longint'(Sum_out), 40);
    feed4(1, 1, 1, 1);
    pin_result("r034", 4);

    // Clear in HOLD with Sum_ready also set.
    drive(1, 8, 1, 1);
    chk("clr_hold_valid", longint'(Sum_valid), 0);
    chk("clr_hold_retain", longint'(Sum_out), 4);

    // Asynchronous reset mid-sum.
    drive(1, 2, 0, 0);
    drive(1, 2, 0, 0);
    drive(1, 2, 0, 0);
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    chk("r035_cnt", longint'(Cnt), 0);
    chk("r035_valid", longint'(Sum_valid), 0);
    chk("r035_p_ready", longint'(P_ready), 1);
    drive(1, 2, 0, 0);
    Reset = 1'b1;
    feed4(5, 5, 5, 5);
    pin_result("r035", 20);
    drive(0, 0, 0, 1);

    // Gaps between products.
    drive(1, 1, 0, 0);
    drive(0, 50, 0, 0);
    drive(1, 2, 0, 0);
    drive(0, 50, 0, 1);
    drive(0, 50, 0, 0);
    drive(1, 3, 0, 0);
    chk("r036_not_yet", longint'(Sum_valid), 0);
    drive(1, 4, 0, 0);
    pin_result("r036", 10);
    drive(0, 0, 0, 1);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0) ? 65535 : longint'($urandom_range(0, 65535)),
            ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 1) == 1));
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
